// File: rtl/mlp_pkg.sv
// Shared FSM encoding and default network dimensions for the MLP MAC sequencer.
// The total-weights constant is also consumed by the weight ROM generator.
package mlp_pkg;

   typedef enum logic [2:0] {IDLE, CLR, MAC, ACT, WB, DONE} state_t;

   localparam int MLP_LAYERS  = 4;
   localparam int MLP_NEURONS = 10;
   localparam int MLP_FANIN0  = 62;
   localparam int MLP_FANIN   = 10;

   function automatic int total_weights(input int layers, input int neurons,
                                        input int fanin0, input int fanin);
      return fanin0 * neurons + (layers - 1) * fanin * neurons;
   endfunction

   localparam int MLP_TOTAL_WEIGHTS =
      total_weights(MLP_LAYERS, MLP_NEURONS, MLP_FANIN0, MLP_FANIN);

endpackage

// File: rtl/mlp_wrap_counter.sv
// Wrapping up-counter: steps on en, returns to zero after last_val, synchronous clear.
// tc is combinational from the count so callers can act in the same cycle.
module mlp_wrap_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] last_val,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_d, cnt_q;

   assign tc  = (cnt_q == last_val);
   assign cnt = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mlp_mac_scheduler.sv
// Walks layers/neurons/fan-in for a single shared MAC; CLR, fan-in MACs, ACT, WB per neuron.
// hold stalls only the MAC phase, one cycle per stalled cycle; start is sampled only in IDLE.
module mlp_mac_scheduler
   import mlp_pkg::*;
#(
   parameter int LAYERS  = MLP_LAYERS,
   parameter int NEURONS = MLP_NEURONS,
   parameter int FANIN0  = MLP_FANIN0,
   parameter int FANIN   = MLP_FANIN,
   parameter int WADDR_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               hold,
   output logic               busy,
   output logic               done,
   output logic               mac_clr,
   output logic               mac_en,
   output logic [WADDR_W-1:0] weight_addr,
   output logic [5:0]         in_sel,
   output logic [1:0]         layer,
   output logic [3:0]         neuron,
   output logic               act_en,
   output logic               wr_en
);

   localparam logic [5:0] K_LAST0 = 6'(FANIN0 - 1);
   localparam logic [5:0] K_LAST  = 6'(FANIN - 1);
   localparam logic [3:0] N_LAST  = 4'(NEURONS - 1);
   localparam logic [1:0] L_LAST  = 2'(LAYERS - 1);

   state_t             state_d, state_q;
   logic [WADDR_W-1:0] weight_addr_d, weight_addr_q;
   logic               busy_d, busy_q, done_d, done_q;
   logic               mac_clr_d, mac_clr_q, act_en_d, act_en_q, wr_en_d, wr_en_q;

   logic       idle, mac_go, wb;
   logic       k_tc, neuron_tc, layer_tc;
   logic [5:0] k_cnt;
   logic [3:0] neuron_cnt;
   logic [1:0] layer_cnt;

   assign idle   = (state_q == IDLE);
   assign wb     = (state_q == WB);
   assign mac_go = (state_q == MAC) && !hold;

   // k wraps at the fan-in of the current layer, which ends the MAC phase
   mlp_wrap_counter #(.W(6)) u_k_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (mac_go),
      .clr      (idle),
      .last_val ((layer_cnt == 2'd0) ? K_LAST0 : K_LAST),
      .cnt      (k_cnt),
      .tc       (k_tc)
   );

   mlp_wrap_counter #(.W(4)) u_neuron_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (wb),
      .clr      (idle),
      .last_val (N_LAST),
      .cnt      (neuron_cnt),
      .tc       (neuron_tc)
   );

   mlp_wrap_counter #(.W(2)) u_layer_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (wb && neuron_tc),
      .clr      (idle),
      .last_val (L_LAST),
      .cnt      (layer_cnt),
      .tc       (layer_tc)
   );

   always_comb begin
      state_d       = state_q;
      weight_addr_d = weight_addr_q;
      case (state_q)
         IDLE: begin
            weight_addr_d = '0;
            if (start) state_d = CLR;
         end
         CLR:  state_d = MAC;
         MAC: begin
            // address keeps running across neurons and layers: packing is implicit
            if (mac_go) begin
               weight_addr_d = weight_addr_q + WADDR_W'(1);
               if (k_tc) state_d = ACT;
            end
         end
         ACT:  state_d = WB;
         WB:   state_d = (neuron_tc && layer_tc) ? DONE : CLR;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
      mac_clr_d = (state_d == CLR);
      act_en_d  = (state_d == ACT);
      wr_en_d   = (state_d == WB);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         weight_addr_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mac_clr_q     <= 1'b0;
         act_en_q      <= 1'b0;
         wr_en_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         weight_addr_q <= weight_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         mac_clr_q     <= mac_clr_d;
         act_en_q      <= act_en_d;
         wr_en_q       <= wr_en_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign mac_clr     = mac_clr_q;
   assign mac_en      = mac_go;
   assign act_en      = act_en_q;
   assign wr_en       = wr_en_q;
   assign weight_addr = weight_addr_q;
   assign in_sel      = k_cnt;
   assign layer       = layer_cnt;
   assign neuron      = neuron_cnt;

endmodule
